// File: rtl/button_repeat.sv
// Classifies each debounced press into press / long-press / auto-repeat / release events.
// Hold and repeat timing advance only on the external tick enable.
module button_repeat #(
   parameter int HOLD_TICKS   = 500,
   parameter int REPEAT_TICKS = 100,
   parameter int CNT_BITS     = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                tick,
   input  logic                btn_level,
   input  logic                btn_rise,
   input  logic                btn_fall,
   output logic                press,
   output logic                long_press,
   output logic                repeat_pulse,
   output logic                release_pulse,
   output logic                holding,
   output logic [CNT_BITS-1:0] held_ticks
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_REPEAT = 2'd2
   } state_t;

   localparam logic [CNT_BITS-1:0] HOLD_LAST = CNT_BITS'(HOLD_TICKS - 1);
   localparam logic [CNT_BITS-1:0] REP_LAST  = CNT_BITS'(REPEAT_TICKS - 1);
   localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;

   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   state_t              state_q, state_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [CNT_BITS-1:0] held_q, held_d;
   logic                press_q, press_d;
   logic                long_q, long_d;
   logic                rep_q, rep_d;
   logic                rel_q, rel_d;
   logic                holding_q, holding_d;
   logic                rel_cond;

   // Next-state: a release always wins over a tick that would expire a timer.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      held_d    = held_q;
      press_d   = 1'b0;
      long_d    = 1'b0;
      rep_d     = 1'b0;
      rel_d     = 1'b0;
      rel_cond  = btn_fall | ~btn_level;
      unique case (state_q)
         S_IDLE: begin
            if (btn_rise) begin
               press_d = 1'b1;
               state_d = S_HOLD;
               cnt_d   = '0;
               held_d  = '0;
            end
         end
         S_HOLD: begin
            if (rel_cond) begin
               rel_d   = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (tick) begin
               held_d = sat_inc(held_q);
               if (cnt_q == HOLD_LAST) begin
                  long_d  = 1'b1;
                  rep_d   = 1'b1;
                  state_d = S_REPEAT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         S_REPEAT: begin
            if (rel_cond) begin
               rel_d   = 1'b1;
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (tick) begin
               held_d = sat_inc(held_q);
               if (cnt_q == REP_LAST) begin
                  rep_d = 1'b1;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      holding_d = (state_d != S_IDLE);
   end

   // Registered outputs; reset drops any in-flight press without a release pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         held_q    <= '0;
         press_q   <= 1'b0;
         long_q    <= 1'b0;
         rep_q     <= 1'b0;
         rel_q     <= 1'b0;
         holding_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         held_q    <= held_d;
         press_q   <= press_d;
         long_q    <= long_d;
         rep_q     <= rep_d;
         rel_q     <= rel_d;
         holding_q <= holding_d;
      end
   end

   assign press         = press_q;
   assign long_press    = long_q;
   assign repeat_pulse  = rep_q;
   assign release_pulse = rel_q;
   assign holding       = holding_q;
   assign held_ticks    = held_q;

endmodule
